// File: rtl/std_mcfifo.sv
// Multi-channel synchronous FIFO: CH_NUM independent queues sharing one clock, with
// per-channel flags and occupancy, reject pulses and a sticky error. Read path is "std" or "fwft".
module std_mcfifo #(
  parameter int unsigned CH_NUM           = 4,
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned FIFO_DEPTH       = 16,
  parameter int unsigned CNT_WIDTH        = $clog2(FIFO_DEPTH) + 1,
  parameter int unsigned PROG_FULL_THRESH = FIFO_DEPTH - 4,
  parameter string       READ_MODE        = "std"
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [CH_NUM-1:0]              wen,
  input  logic [CH_NUM*DATA_WIDTH-1:0]   wdata,
  input  logic [CH_NUM-1:0]              ren,
  output logic [CH_NUM*DATA_WIDTH-1:0]   rdata,
  output logic [CH_NUM-1:0]              rvalid,
  output logic [CH_NUM-1:0]              empty,
  output logic [CH_NUM-1:0]              full,
  output logic [CH_NUM-1:0]              afull,
  output logic [CH_NUM*CNT_WIDTH-1:0]    cnt,
  output logic [CH_NUM-1:0]              overflow,
  output logic [CH_NUM-1:0]              underflow,
  input  logic                           err_clr,
  output logic                           err
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam bit          Fwft = (READ_MODE == "fwft");

  logic [CH_NUM-1:0] ovf_ev;
  logic [CH_NUM-1:0] unf_ev;
  logic              err_q, err_d;

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]       wptr_q, rptr_q;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  empty_q, full_q, afull_q, ovf_q, unf_q;
    logic                  wr_acc, rd_acc;
    logic [DATA_WIDTH-1:0] wd;

    assign wd        = wdata[i*DATA_WIDTH +: DATA_WIDTH];
    // Acceptance uses the registered flags, so a read cannot make room for a same-edge write.
    assign wr_acc    = wen[i] & ~full_q;
    assign rd_acc    = ren[i] & ~empty_q;
    assign ovf_ev[i] = wen[i] & full_q;
    assign unf_ev[i] = ren[i] & empty_q;

    always_comb begin
      cnt_d = cnt_q;
      if (wr_acc && !rd_acc) begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end else if (!wr_acc && rd_acc) begin
        cnt_d = cnt_q - CNT_WIDTH'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (wr_acc) begin
        mem_q[wptr_q] <= wd;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wptr_q  <= '0;
        rptr_q  <= '0;
        cnt_q   <= '0;
        empty_q <= 1'b1;
        full_q  <= 1'b0;
        afull_q <= 1'b0;
        ovf_q   <= 1'b0;
        unf_q   <= 1'b0;
      end else begin
        if (wr_acc) wptr_q <= wptr_q + PtrW'(1);
        if (rd_acc) rptr_q <= rptr_q + PtrW'(1);
        cnt_q   <= cnt_d;
        empty_q <= (cnt_d == '0);
        full_q  <= (cnt_d == CNT_WIDTH'(FIFO_DEPTH));
        afull_q <= (cnt_d >= CNT_WIDTH'(PROG_FULL_THRESH));
        ovf_q   <= ovf_ev[i];
        unf_q   <= unf_ev[i];
      end
    end

    assign empty[i]                       = empty_q;
    assign full[i]                        = full_q;
    assign afull[i]                       = afull_q;
    assign overflow[i]                    = ovf_q;
    assign underflow[i]                   = unf_q;
    assign cnt[i*CNT_WIDTH +: CNT_WIDTH]  = cnt_q;

    if (Fwft) begin : g_fwft
      // Head entry is exposed directly; zeroed while empty so unwritten storage never leaks out.
      assign rdata[i*DATA_WIDTH +: DATA_WIDTH] = empty_q ? '0 : mem_q[rptr_q];
      assign rvalid[i]                         = ~empty_q;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] rdata_q;
      logic                  rvalid_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rdata_q  <= '0;
          rvalid_q <= 1'b0;
        end else begin
          rvalid_q <= rd_acc;
          if (rd_acc) rdata_q <= mem_q[rptr_q];
        end
      end

      assign rdata[i*DATA_WIDTH +: DATA_WIDTH] = rdata_q;
      assign rvalid[i]                         = rvalid_q;
    end
  end

  // A new reject event takes priority over a clear arriving on the same edge.
  always_comb begin
    err_d = err_q;
    if (|{ovf_ev, unf_ev}) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;

endmodule

// File: tb/tb_std_mcfifo.sv
// Bench for std_mcfifo: queue-per-channel reference model driven by directed and random traffic,
// plus a second instance in first-word fall-through mode.
module tb_std_mcfifo;

  localparam int CH    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int CW    = 5;
  localparam int THR   = 12;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [CH-1:0]     wen, ren;
  logic [CH*DW-1:0]  wdata;
  logic              err_clr;
  logic [CH*DW-1:0]  rdata;
  logic [CH-1:0]     rvalid, empty, full, afull, overflow, underflow;
  logic [CH*CW-1:0]  cnt;
  logic              err;

  logic [CH-1:0]     f_wen, f_ren;
  logic [CH*DW-1:0]  f_wdata;
  logic              f_err_clr;
  logic [CH*DW-1:0]  f_rdata;
  logic [CH-1:0]     f_rvalid, f_empty, f_full, f_afull, f_overflow, f_underflow;
  logic [CH*CW-1:0]  f_cnt;
  logic              f_err;

  always #5 clk = ~clk;

  std_mcfifo #(.CH_NUM(CH), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .READ_MODE("std")) u_dut (
    .clk(clk), .rst_n(rst_n), .wen(wen), .wdata(wdata), .ren(ren), .rdata(rdata),
    .rvalid(rvalid), .empty(empty), .full(full), .afull(afull), .cnt(cnt),
    .overflow(overflow), .underflow(underflow), .err_clr(err_clr), .err(err)
  );

  std_mcfifo #(.CH_NUM(CH), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .READ_MODE("fwft")) u_fwft (
    .clk(clk), .rst_n(rst_n), .wen(f_wen), .wdata(f_wdata), .ren(f_ren), .rdata(f_rdata),
    .rvalid(f_rvalid), .empty(f_empty), .full(f_full), .afull(f_afull), .cnt(f_cnt),
    .overflow(f_overflow), .underflow(f_underflow), .err_clr(f_err_clr), .err(f_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: one queue per channel plus the expected registered outputs.
  logic [DW-1:0]    mq [CH][$];
  logic [DW-1:0]    exp_rd [CH];
  logic [CH-1:0]    exp_rv, exp_ovf, exp_unf, exp_empty, exp_full, exp_afull;
  logic             exp_err;
  logic [CH*DW-1:0] exp_rdata_v;
  logic [CH*CW-1:0] exp_cnt_v;

  task automatic upd_exp();
    for (int c = 0; c < CH; c++) begin
      exp_cnt_v[c*CW +: CW]   = CW'(mq[c].size());
      exp_empty[c]            = (mq[c].size() == 0);
      exp_full[c]             = (mq[c].size() == DEPTH);
      exp_afull[c]            = (mq[c].size() >= THR);
      exp_rdata_v[c*DW +: DW] = exp_rd[c];
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      mq[c].delete();
      exp_rd[c] = '0;
    end
    exp_rv  = '0;
    exp_ovf = '0;
    exp_unf = '0;
    exp_err = 1'b0;
    upd_exp();
  endtask

  // Drive one cycle of stimulus, advance the model by the same edge, sample 1ns after it.
  task automatic tick(input logic [CH-1:0] w, input logic [CH-1:0] r,
                      input logic [CH*DW-1:0] wd, input logic clr);
    logic any_ev;
    wen = w; ren = r; wdata = wd; err_clr = clr;
    any_ev = 1'b0;
    for (int c = 0; c < CH; c++) begin
      int sz;
      sz = mq[c].size();
      exp_ovf[c] = w[c] && (sz == DEPTH);
      exp_unf[c] = r[c] && (sz == 0);
      any_ev = any_ev | exp_ovf[c] | exp_unf[c];
      exp_rv[c] = 1'b0;
      if (r[c] && sz > 0) begin
        exp_rd[c] = mq[c].pop_front();
        exp_rv[c] = 1'b1;
      end
      if (w[c] && sz < DEPTH) mq[c].push_back(wd[c*DW +: DW]);
    end
    if (any_ev) exp_err = 1'b1;
    else if (clr) exp_err = 1'b0;
    @(posedge clk);
    #1;
    wen = '0; ren = '0; err_clr = 1'b0;
    upd_exp();
  endtask

  task automatic test_reset();
    n_cmp++; if (empty !== {CH{1'b1}}) begin n_bad++; $display("FAIL reset_empty got=%h exp=%h", empty, {CH{1'b1}}); end
    n_cmp++; if (cnt !== '0) begin n_bad++; $display("FAIL reset_cnt got=%h exp=0", cnt); end
    n_cmp++; if ({full, afull, rvalid} !== '0) begin n_bad++; $display("FAIL reset_flags got=%h exp=0", {full, afull, rvalid}); end
    n_cmp++; if ({overflow, underflow, err} !== '0) begin n_bad++; $display("FAIL reset_err got=%h exp=0", {overflow, underflow, err}); end
    n_cmp++; if (rdata !== '0) begin n_bad++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    n_cmp++; if (f_empty !== {CH{1'b1}}) begin n_bad++; $display("FAIL reset_fwft_empty got=%h exp=%h", f_empty, {CH{1'b1}}); end
  endtask

  task automatic test_fwft();
    f_wdata = '0;
    f_wdata[2*DW +: DW] = 32'hA5A5A5A5;
    f_wen = 4'b0100;
    @(posedge clk); #1; f_wen = '0;
    n_cmp++; if (f_empty[2] !== 1'b0) begin n_bad++; $display("FAIL fwft_empty got=%b exp=0", f_empty[2]); end
    n_cmp++; if (f_rvalid[2] !== 1'b1) begin n_bad++; $display("FAIL fwft_rvalid got=%b exp=1", f_rvalid[2]); end
    n_cmp++; if (f_rdata[2*DW +: DW] !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL fwft_rdata got=%h exp=a5a5a5a5", f_rdata[2*DW +: DW]); end
    f_wdata[2*DW +: DW] = 32'h12345678;
    f_wen = 4'b0100;
    @(posedge clk); #1; f_wen = '0;
    n_cmp++; if (f_rdata[2*DW +: DW] !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL fwft_head got=%h exp=a5a5a5a5", f_rdata[2*DW +: DW]); end
    n_cmp++; if (f_cnt[2*CW +: CW] !== 5'd2) begin n_bad++; $display("FAIL fwft_cnt got=%0d exp=2", f_cnt[2*CW +: CW]); end
    f_ren = 4'b0100;
    @(posedge clk); #1;
    n_cmp++; if (f_rdata[2*DW +: DW] !== 32'h12345678) begin n_bad++; $display("FAIL fwft_pop got=%h exp=12345678", f_rdata[2*DW +: DW]); end
    @(posedge clk); #1; f_ren = '0;
    n_cmp++; if ({f_empty[2], f_rvalid[2]} !== 2'b10) begin n_bad++; $display("FAIL fwft_drained got=%b exp=10", {f_empty[2], f_rvalid[2]}); end
    n_cmp++; if ({f_full, f_afull, f_overflow, f_underflow, f_err} !== '0) begin n_bad++; $display("FAIL fwft_quiet got=%h exp=0", {f_full, f_afull, f_overflow, f_underflow, f_err}); end
  endtask

  task automatic test_fill_drain();
    logic [CH*DW-1:0] wd;
    for (int i = 0; i < DEPTH; i++) begin
      wd = '0; wd[DW-1:0] = DW'(i);
      tick(4'b0001, 4'b0000, wd, 1'b0);
      n_cmp++; if (cnt[CW-1:0] !== CW'(i + 1)) begin n_bad++; $display("FAIL fill_cnt got=%0d exp=%0d", cnt[CW-1:0], i + 1); end
      n_cmp++; if (afull[0] !== (i + 1 >= THR)) begin n_bad++; $display("FAIL fill_afull got=%b exp=%b at %0d", afull[0], (i + 1 >= THR), i); end
      n_cmp++; if (full[0] !== (i == DEPTH - 1)) begin n_bad++; $display("FAIL fill_full got=%b exp=%b at %0d", full[0], (i == DEPTH - 1), i); end
    end
    wd = '0; wd[DW-1:0] = 32'hDEAD;
    tick(4'b0001, 4'b0000, wd, 1'b0);
    n_cmp++; if ({overflow[0], err} !== 2'b11) begin n_bad++; $display("FAIL ovf_pulse got=%b exp=11", {overflow[0], err}); end
    n_cmp++; if (cnt[CW-1:0] !== 5'd16) begin n_bad++; $display("FAIL ovf_cnt got=%0d exp=16", cnt[CW-1:0]); end
    tick('0, '0, '0, 1'b0);
    n_cmp++; if ({overflow[0], err} !== 2'b01) begin n_bad++; $display("FAIL ovf_one_cycle got=%b exp=01", {overflow[0], err}); end
    for (int i = 0; i < DEPTH; i++) begin
      tick(4'b0000, 4'b0001, '0, 1'b0);
      n_cmp++; if (rvalid[0] !== 1'b1) begin n_bad++; $display("FAIL drain_rvalid got=%b exp=1 at %0d", rvalid[0], i); end
      n_cmp++; if (rdata[DW-1:0] !== DW'(i)) begin n_bad++; $display("FAIL drain_rdata got=%h exp=%h", rdata[DW-1:0], i); end
    end
    tick(4'b0000, 4'b0001, '0, 1'b0);
    n_cmp++; if ({underflow[0], empty[0], rvalid[0]} !== 3'b110) begin n_bad++; $display("FAIL unf_pulse got=%b exp=110", {underflow[0], empty[0], rvalid[0]}); end
    tick('0, '0, '0, 1'b1);
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_clear got=%b exp=0", err); end
    n_cmp++; if (rdata[DW-1:0] !== 32'd15) begin n_bad++; $display("FAIL rdata_hold got=%h exp=f", rdata[DW-1:0]); end
  endtask

  task automatic test_wrap();
    logic [CH*DW-1:0] wd;
    for (int i = 0; i < 8; i++) begin
      wd = '0; wd[DW +: DW] = $urandom;
      tick(4'b0010, 4'b0000, wd, 1'b0);
    end
    for (int i = 0; i < 40; i++) begin
      wd = '0; wd[DW +: DW] = $urandom;
      tick(4'b0010, 4'b0010, wd, 1'b0);
      n_cmp++; if (cnt[CW +: CW] !== 5'd8) begin n_bad++; $display("FAIL wrap_cnt got=%0d exp=8", cnt[CW +: CW]); end
      n_cmp++; if ({rvalid[1], rdata[DW +: DW]} !== {1'b1, exp_rd[1]}) begin n_bad++; $display("FAIL wrap_data got=%h exp=%h", rdata[DW +: DW], exp_rd[1]); end
    end
    for (int i = 0; i < 8; i++) begin
      tick(4'b0000, 4'b0010, '0, 1'b0);
      n_cmp++; if (rdata[DW +: DW] !== exp_rd[1]) begin n_bad++; $display("FAIL wrap_drain got=%h exp=%h", rdata[DW +: DW], exp_rd[1]); end
    end
    n_cmp++; if (empty[1] !== 1'b1) begin n_bad++; $display("FAIL wrap_empty got=%b exp=1", empty[1]); end
  endtask

  task automatic test_simul_empty();
    logic [CH*DW-1:0] wd;
    wd = '0; wd[3*DW +: DW] = 32'h0BAD_F00D;
    tick(4'b1000, 4'b1000, wd, 1'b0);
    n_cmp++; if ({underflow[3], err} !== 2'b11) begin n_bad++; $display("FAIL simul_unf got=%b exp=11", {underflow[3], err}); end
    n_cmp++; if (cnt[3*CW +: CW] !== 5'd1) begin n_bad++; $display("FAIL simul_cnt got=%0d exp=1", cnt[3*CW +: CW]); end
    n_cmp++; if ({empty[3], rvalid[3]} !== 2'b00) begin n_bad++; $display("FAIL simul_flags got=%b exp=00", {empty[3], rvalid[3]}); end
    tick('0, '0, '0, 1'b1);
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL simul_clr got=%b exp=0", err); end
    for (int i = 1; i < DEPTH; i++) begin
      wd[3*DW +: DW] = $urandom;
      tick(4'b1000, 4'b0000, wd, 1'b0);
    end
    n_cmp++; if (full[3] !== 1'b1) begin n_bad++; $display("FAIL simul_full got=%b exp=1", full[3]); end
    tick(4'b1000, 4'b1000, wd, 1'b1);
    n_cmp++; if ({overflow[3], err} !== 2'b11) begin n_bad++; $display("FAIL set_beats_clr got=%b exp=11", {overflow[3], err}); end
    n_cmp++; if (cnt[3*CW +: CW] !== 5'd15) begin n_bad++; $display("FAIL full_rw_cnt got=%0d exp=15", cnt[3*CW +: CW]); end
  endtask

  task automatic test_random();
    logic [CH-1:0]    w, r;
    logic [CH*DW-1:0] wd;
    for (int i = 0; i < 300; i++) begin
      if (i == 150) begin
        rst_n = 1'b0;
        #2;
        model_reset();
        n_cmp++; if ({empty, full, afull, rvalid} !== {{CH{1'b1}}, {(3*CH){1'b0}}}) begin n_bad++; $display("FAIL mid_reset_flags got=%h", {empty, full, afull, rvalid}); end
        n_cmp++; if ({cnt, overflow, underflow, err} !== '0) begin n_bad++; $display("FAIL mid_reset_cnt got=%h exp=0", {cnt, overflow, underflow, err}); end
        n_cmp++; if (rdata !== '0) begin n_bad++; $display("FAIL mid_reset_rdata got=%h exp=0", rdata); end
        @(posedge clk); #1;
        rst_n = 1'b1;
      end
      for (int c = 0; c < CH; c++) begin
        w[c] = ($urandom_range(0, 99) < ((i % 150) < 90 ? 75 : 30));
        r[c] = ($urandom_range(0, 99) < 45);
        wd[c*DW +: DW] = $urandom;
      end
      tick(w, r, wd, ($urandom_range(0, 9) == 0));
      n_cmp++; if (cnt !== exp_cnt_v) begin n_bad++; $display("FAIL rand_cnt got=%h exp=%h", cnt, exp_cnt_v); end
      n_cmp++; if ({empty, full, afull} !== {exp_empty, exp_full, exp_afull}) begin n_bad++; $display("FAIL rand_flags got=%h exp=%h", {empty, full, afull}, {exp_empty, exp_full, exp_afull}); end
      n_cmp++; if ({overflow, underflow, err} !== {exp_ovf, exp_unf, exp_err}) begin n_bad++; $display("FAIL rand_err got=%h exp=%h", {overflow, underflow, err}, {exp_ovf, exp_unf, exp_err}); end
      n_cmp++; if (rvalid !== exp_rv) begin n_bad++; $display("FAIL rand_rvalid got=%b exp=%b", rvalid, exp_rv); end
      n_cmp++; if (rdata !== exp_rdata_v) begin n_bad++; $display("FAIL rand_rdata got=%h exp=%h", rdata, exp_rdata_v); end
    end
  endtask

  initial begin
    wen = '0; ren = '0; wdata = '0; err_clr = 1'b0;
    f_wen = '0; f_ren = '0; f_wdata = '0; f_err_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    test_fwft();
    test_fill_drain();
    test_wrap();
    test_simul_empty();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/std_mcfifo.md
STD_MCFIFO -- requirements
Module: std_mcfifo

Interface
REQ-001 SHALL have parameter CH_NUM, default 4: number of independent FIFO channels, 1..16.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: data bits per channel.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16: entries per channel; power of 2, 4..256.
REQ-004 SHALL have parameter CNT_WIDTH, default $clog2(FIFO_DEPTH)+1: per-channel count width.
REQ-005 SHALL have parameter PROG_FULL_THRESH, default FIFO_DEPTH-4: afull threshold, 1..FIFO_DEPTH-1.
REQ-006 SHALL have parameter READ_MODE, default "std": "std" (1-cycle read latency) or "fwft" (first-word fall-through).
REQ-007 SHALL have ports:
  clk        in   1                    single clock, all logic posedge
  rst_n      in   1                    asynchronous active-low reset
  wen        in   CH_NUM               per-channel write request
  wdata      in   CH_NUM*DATA_WIDTH    channel i data at [i*DATA_WIDTH +: DATA_WIDTH]
  ren        in   CH_NUM               per-channel read request
  rdata      out  CH_NUM*DATA_WIDTH    per-channel read data, same packing
  rvalid     out  CH_NUM               rdata valid for channel
  empty      out  CH_NUM               channel holds no entries
  full       out  CH_NUM               channel holds FIFO_DEPTH entries
  afull      out  CH_NUM               count >= PROG_FULL_THRESH
  cnt        out  CH_NUM*CNT_WIDTH     per-channel occupancy
  overflow   out  CH_NUM               1-cycle pulse: write rejected
  underflow  out  CH_NUM               1-cycle pulse: read rejected
  err_clr    in   1                    clears err
  err        out  1                    sticky OR of any overflow/underflow

Function
REQ-008 Channels SHALL be fully independent; storage, pointers, flags per channel; no cross-channel arbitration.
REQ-009 Write on channel i SHALL be accepted iff wen[i] && !full[i] (pre-edge flag); full write with simultaneous read still rejected.
REQ-010 Read on channel i SHALL be accepted iff ren[i] && !empty[i] (pre-edge flag).
REQ-011 Write and read pointers SHALL be $clog2(FIFO_DEPTH) bits, increment per accepted op, wrap FIFO_DEPTH-1 -> 0.
REQ-012 cnt SHALL update same edge: +1 write only, -1 read only, unchanged both or neither; never exceeds FIFO_DEPTH nor below 0.
REQ-013 empty = (cnt==0), full = (cnt==FIFO_DEPTH), afull = (cnt>=PROG_FULL_THRESH); all registered, consistent with cnt every cycle.
REQ-014 Simultaneous wen and ren on empty channel: write accepted, read rejected, underflow pulsed, cnt becomes 1.
REQ-015 overflow[i] SHALL pulse one cycle after edge where wen[i] && full[i]; underflow[i] likewise for ren[i] && empty[i]; rejected ops change no state.
REQ-016 err SHALL set on any overflow/underflow pulse, hold until err_clr; set wins over simultaneous err_clr.
REQ-017 "std": accepted read at edge N SHALL drive head data on rdata and rvalid=1 in cycle after N; rvalid=0 otherwise; rdata holds last value when no read.
REQ-018 "fwft": rdata SHALL present head entry whenever empty=0; rvalid = !empty; accepted ren pops, next entry visible following cycle.
REQ-019 Write to empty channel SHALL clear empty one cycle after write edge in both modes (fwft data valid that same cycle).
REQ-020 Storage arrays SHALL not be reset; contents undefined until written.

Reset
REQ-021 rst_n low SHALL asynchronously force: pointers 0, cnt 0, empty all 1, full/afull/rvalid/overflow/underflow all 0, rdata 0, err 0.
REQ-022 Reset mid-operation SHALL discard all contents; first post-reset accepted read returns first post-reset write.
REQ-023 Release SHALL be synchronous to clk by upstream; first ops accepted at first edge with rst_n high.

Verification
REQ-024 Fill ch0 (DEPTH=16, "std") with 0..15 -> full[0]=1 after 16th write, afull[0]=1 from cnt=12, cnt[0]=16; 17th wen -> overflow[0] pulse, err=1, cnt stays 16.
REQ-025 Drain ch0 with ren held -> rdata 0..15 in order, each one cycle after read, rvalid=1 for 16 cycles; 17th ren -> underflow[0] pulse, empty=1.
REQ-026 Wrap test: 40 writes/reads interleaved at cnt 8 on ch1 -> order preserved across pointer wrap, cnt[1] constant 8 during simultaneous ops.
REQ-027 "fwft" mode: write 0xA5A5A5A5 to empty ch2 -> next cycle empty[2]=0, rvalid[2]=1, rdata ch2=0xA5A5A5A5 without ren.
REQ-028 Channels 0..3 driven with random wen/ren, reset asserted mid-stream -> all flags, cnt, err return to reset values immediately; scoreboard per channel matches.
REQ-029 wen+ren same cycle on empty ch3 -> underflow[3] pulse, cnt[3]=1; err_clr with concurrent new overflow -> err stays 1.
